ifu_fetch_master: RTL
=====================

# ifu_fetch_master

Instruction-fetch initiator for the core front end. Owns the architectural fetch PC and issues one outstanding read at a time on the AXI-lite-style AR/R channels toward the instruction memory responder. Presents each returned instruction with its PC to decode over a valid/ready port. Accepts redirects from execute (branch, jump, trap) without violating channel handshake rules.

## Interface
- RESET_PC, 32'h8000_0000, PC of the first fetch after reset.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- araddr  out  32  read address; equals the current fetch PC.
- arvalid  out  1  read-address request.
- arready  in  1  responder accepts the address.
- rdata  in  32  returned instruction word.
- rresp  in  2  2'b00 OKAY; any other value is an error.
- rvalid  in  1  read data valid.
- rready  out  1  master ready for read data.
- out_inst  out  32  instruction delivered to decode.
- out_pc  out  32  PC of out_inst.
- out_valid  out  1  out_inst/out_pc valid.
- out_ready  in  1  decode accepts the current instruction.
- redirect_valid  in  1  one-cycle request to change the fetch PC.
- redirect_pc  in  32  target PC; bits [1:0] are forced to 0.
- fetch_err  out  1  sticky; set on a non-OKAY response.

## Operation
- States: IDLE, AR, R, OUT, HALT. Reset enters IDLE with pc=RESET_PC, no redirect pending, fetch_err=0. IDLE moves to AR unconditionally on the next edge.
- AR: arvalid=1, araddr=pc. On arvalid&&arready, go to R. araddr and arvalid hold stable until the handshake completes; a redirect never drops or changes them mid-request.
- R: rready=1. On rvalid&&rready:
  - rresp!=0: set fetch_err and go to HALT.
  - A redirect is pending or arrives this cycle: discard the data, set pc=target, clear the pending flag, go to AR.
  - Otherwise: latch rdata into out_inst and pc into out_pc, go to OUT.
- OUT: out_valid=1.
  - redirect_valid: drop the instruction, set pc=redirect target, go to AR. out_valid=0 next cycle, even if out_ready was high the same cycle; the redirect wins.
  - Else on out_ready: pc=pc+4 (mod 2^32), go to AR.
- HALT: all outputs idle; only reset exits.
- Redirect captured in AR or R sets a one-entry pending register holding the target. A later redirect overwrites it (last wins). Pending is applied at the R completion.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC+4 to 32'h0000_0000.
- Exactly one read outstanding at any time.

## Timing
- Reset values: arvalid=0, rready=0, out_valid=0, fetch_err=0, araddr=RESET_PC, out_inst=0, out_pc=0.
- arvalid is asserted in the first cycle after reset deasserts plus one (IDLE cycle).
- Minimum fetch-to-deliver latency, with arready=1 and rvalid returned in the cycle after the AR handshake:
  - cycle n: AR handshake.
  - cycle n+1: R handshake.
  - cycle n+2: out_valid=1.
- Peak throughput: one instruction per 3 cycles.
- rready=1 only in R; arvalid=1 only in AR. Both are registered-state decodes with no combinational path from inputs.
- out_inst and out_pc are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-transaction returns to IDLE asynchronously. A responder beat arriving afterward is ignored because rready=0.

## Test plan
- Reset release with arready=1 and 1-cycle memory returning 32'h00000013 -> araddr=32'h80000000 and out_valid at the 4th edge after reset, with out_pc=32'h80000000. The next araddr is 32'h80000004.
- arready held low for 5 cycles, with redirect_valid to 32'h80000100 in cycle 2 -> araddr stays 32'h80000000 until the handshake. The response is discarded and the next araddr is 32'h80000100.
- Decode stalls (out_ready=0) for 4 cycles -> out_inst/out_pc are held constant, no new arvalid is issued, and pc advances by 4 only after the accept.
- In OUT, out_ready=1 and redirect_valid=1 to 32'h80000203 in the same cycle -> the instruction is dropped and the next araddr is 32'h80000200.
- rresp=2'b10 on the second fetch -> fetch_err=1, out_valid stays 0 and arvalid stays 0 until reset. Asserting reset clears fetch_err.
- RESET_PC=32'hFFFFFFFC, one accepted instruction -> the next araddr is 32'h00000000.

Source files
------------

// File: rtl/ifu_fetch_master_if.sv
// ifu_fetch_master_if: AR/R read channels, decode output port, redirect input and error flag
interface ifu_fetch_master_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_valid;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;
  modport master (
    output araddr, arvalid, rready, out_inst, out_pc, out_valid, fetch_err,
    input  arready, rdata, rresp, rvalid, out_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  araddr, arvalid, rready, out_inst, out_pc, out_valid, fetch_err,
    output arready, rdata, rresp, rvalid, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_fetch_master.sv
// ifu_fetch_master: single-outstanding instruction fetch initiator with redirect handling
module ifu_fetch_master #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic               clk,
  input logic               reset,
  ifu_fetch_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, AR, R, OUT, HALT} state_t;
  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_pc_q;
  logic        pend_q;
  logic [31:0] inst_q;
  logic [31:0] opc_q;
  logic        err_q;
  logic [31:0] redir_pc;
  assign redir_pc = {bus.redirect_pc[31:2], 2'b00};
  // Fetch FSM: a redirect seen while a read is in flight is parked and applied when the data returns
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      pend_q    <= 1'b0;
      inst_q    <= '0;
      opc_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= AR;
        AR: begin
          if (bus.redirect_valid) begin
            pend_q    <= 1'b1;
            pend_pc_q <= redir_pc;
          end
          if (bus.arready) state_q <= R;
        end
        R: begin
          if (bus.rvalid) begin
            if (bus.rresp != 2'b00) begin
              err_q   <= 1'b1;
              state_q <= HALT;
            end else if (bus.redirect_valid || pend_q) begin
              pc_q    <= bus.redirect_valid ? redir_pc : pend_pc_q;
              pend_q  <= 1'b0;
              state_q <= AR;
            end else begin
              inst_q  <= bus.rdata;
              opc_q   <= pc_q;
              state_q <= OUT;
            end
          end else if (bus.redirect_valid) begin
            pend_q    <= 1'b1;
            pend_pc_q <= redir_pc;
          end
        end
        OUT: begin
          if (bus.redirect_valid) begin
            pc_q    <= redir_pc;
            state_q <= AR;
          end else if (bus.out_ready) begin
            pc_q    <= pc_q + 32'd4;
            state_q <= AR;
          end
        end
        default: state_q <= HALT;
      endcase
    end
  assign bus.araddr    = pc_q;
  assign bus.arvalid   = state_q == AR;
  assign bus.rready    = state_q == R;
  assign bus.out_valid = state_q == OUT;
  assign bus.out_inst  = inst_q;
  assign bus.out_pc    = opc_q;
  assign bus.fetch_err = err_q;
endmodule
